instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of WAIT or FLUSH cycles without mem_ack before the fetch aborts; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 clr_n  input  1  reset, asynchronous, active-low.
REQ-004 pc_q  input  32  current program counter value from the PC register.
REQ-005 start  input  1  fetch request; sampled only in IDLE.
REQ-006 stall  input  1  while high in IDLE, start is ignored.
REQ-007 redirect  input  1  branch taken or PC overwritten; cancels the in-flight fetch.
REQ-008 err_clr  input  1  clears fetch_err.
REQ-009 mem_addr  output  32  registered fetch address presented to memory.
REQ-010 mem_rd  output  1  read request, held high until the cycle mem_ack is sampled high.
REQ-011 mem_ack  input  1  memory read-data-valid strobe.
REQ-012 mem_data  input  32  read data; valid when mem_ack=1.
REQ-013 ir_q  output  32  captured instruction word.
REQ-014 ir_valid  output  1  one-cycle pulse when ir_q is updated.
REQ-015 pc_inc  output  1  one-cycle pulse to the PC register's inc input; coincident with ir_valid.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 fetch_err  output  1  sticky timeout flag.

Function
REQ-018 The block SHALL implement four states: IDLE, ISSUE, WAIT, and FLUSH.
REQ-019 IDLE: when start=1 and stall=0, the block SHALL latch mem_addr<=pc_q and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 ISSUE: the block SHALL assert mem_rd, clear the timeout counter, and go to WAIT the next cycle; mem_ack is not sampled in ISSUE.
REQ-021 WAIT: mem_rd SHALL remain high and the counter SHALL increment each cycle that mem_ack=0.
REQ-022 WAIT with mem_ack=1 and redirect=0: the block SHALL load ir_q<=mem_data, pulse ir_valid and pc_inc for exactly one cycle (the next cycle), drop mem_rd, and return to IDLE.
REQ-023 WAIT with redirect=1 and mem_ack=0: the block SHALL go to FLUSH with mem_rd still high and the counter continuing.
REQ-024 WAIT with redirect=1 and mem_ack=1 in the same cycle: the data SHALL be discarded, ir_q unchanged, no ir_valid or pc_inc, and the block SHALL go to IDLE.
REQ-025 FLUSH: on mem_ack=1 the data SHALL be discarded, mem_rd dropped, and the block SHALL go to IDLE with no ir_valid or pc_inc.
REQ-026 Timeout: if the counter reaches TIMEOUT-1 in WAIT or FLUSH with mem_ack=0, the block SHALL set fetch_err=1, drop mem_rd, go to IDLE, and emit no pc_inc.
REQ-027 fetch_err SHALL hold until err_clr=1 or reset; if err_clr and a new timeout occur in the same cycle, the timeout wins.
REQ-028 A start received while busy=1 SHALL be ignored and not queued.
REQ-029 A redirect received in IDLE or ISSUE SHALL have no effect; the address latched in IDLE stands.
REQ-030 A mem_ack received in IDLE or ISSUE SHALL be ignored.
REQ-031 fetch_err=1 SHALL NOT block new fetches.
REQ-032 Minimum fetch latency SHALL be: start sampled at edge N, mem_rd high from N+1, ack at N+2, ir_valid and pc_inc high during N+3.

Reset
REQ-033 When clr_n=0, immediately and asynchronously: state=IDLE, mem_addr=0, mem_rd=0, ir_q=0, ir_valid=0, pc_inc=0, busy=0, fetch_err=0, counter=0.
REQ-034 A reset asserted mid-fetch SHALL abandon the fetch with no pulse emitted; after clr_n rises, the first fetch SHALL require a fresh start.

Verification
REQ-035 Bench scenario: pc_q=0x00000040, start for 1 cycle, mem_ack 1 cycle after mem_rd rises with mem_data=0xDEADBEEF -> mem_addr=0x40, ir_q=0xDEADBEEF, ir_valid and pc_inc each exactly one cycle.
REQ-036 Bench scenario: redirect 2 cycles into WAIT, ack 3 cycles later with mem_data=0x12345678 -> ir_q keeps its previous value, no pc_inc, busy falls the cycle after ack.
REQ-037 Bench scenario: redirect and mem_ack in the same cycle -> data dropped, no ir_valid, return to IDLE.
REQ-038 Bench scenario: TIMEOUT=16, mem_ack never asserted -> fetch_err=1 and mem_rd=0 after 16 WAIT cycles; err_clr pulse -> fetch_err=0.
REQ-039 Bench scenario: start pulsed while busy plus a stall=1 start in IDLE -> exactly one fetch and one pc_inc total.
REQ-040 Bench scenario: clr_n low mid-WAIT -> all outputs 0 without waiting for a clock edge; a late mem_ack after release produces no ir_valid.

Source files
------------

// File: rtl/instr_fetch_if.sv
// ============================================================================
// instr_fetch_if : memory read port between the fetch unit and instruction memory
// rev 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [31:0] mem_data;

  modport master (output mem_addr, output mem_rd, input mem_ack, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_ack, output mem_data);
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : single-outstanding instruction fetch FSM with redirect flush
// and ack timeout. rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int unsigned TIMEOUT = 16
) (
  input  wire logic        clk,
  input  wire logic        clr_n,
  input  wire logic [31:0] pc_q,
  input  wire logic        start,
  input  wire logic        stall,
  input  wire logic        redirect,
  input  wire logic        err_clr,
  instr_fetch_if.master    mem,
  output logic      [31:0] ir_q,
  output logic             ir_valid,
  output logic             pc_inc,
  output logic             busy,
  output logic             fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic        rd_q;
  logic        ir_valid_q;
  logic        pc_inc_q;
  logic        busy_q;
  logic        err_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 32'd0;
      rd_q       <= 1'b0;
      ir_q       <= 32'd0;
      ir_valid_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ir_valid_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start && !stall) begin
            addr_q  <= pc_q;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= 8'd0;
          state_q <= WAIT;
        end
        WAIT, FLUSH: begin
          if (mem.mem_ack) begin
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            // A redirect coinciding with the ack, or any earlier one, voids the data.
            if (state_q == WAIT && !redirect) begin
              ir_q       <= mem.mem_data;
              ir_valid_q <= 1'b1;
              pc_inc_q   <= 1'b1;
            end
          end else if (cnt_q == C_CNT_LAST) begin
            // Assigned after err_clr so a coincident timeout keeps the flag set.
            err_q   <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (redirect) begin
              state_q <= FLUSH;
            end
          end
        end
      endcase
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_rd   = rd_q;
  assign ir_valid     = ir_valid_q;
  assign pc_inc       = pc_inc_q;
  assign busy         = busy_q;
  assign fetch_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch : scenario and randomized checks of instr_fetch against a
// transaction-level timing model. rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [31:0] pc_q = 32'd0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] ir_q;
  logic        ir_valid;
  logic        pc_inc;
  logic        busy;
  logic        fetch_err;

  int vecs = 0;
  int fails = 0;
  int n_inc = 0;
  logic [31:0] ir_m = 32'd0;
  logic        err_m = 1'b0;

  instr_fetch_if mem_bus ();

  instr_fetch #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .pc_q      (pc_q),
    .start     (start),
    .stall     (stall),
    .redirect  (redirect),
    .err_clr   (err_clr),
    .mem       (mem_bus),
    .ir_q      (ir_q),
    .ir_valid  (ir_valid),
    .pc_inc    (pc_inc),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pc_inc === 1'b1) n_inc++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start = 1'b0; stall = 1'b0; redirect = 1'b0; err_clr = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_data = 32'd0;
  endtask

  // One fetch described at transaction level: start in cycle 0, mem_rd high from
  // cycle 1, ack in cycle 1+k (k=0: never), redirect in cycle rr (-1: none).
  // The fetch ends in cycle E (ack cycle or last timeout cycle); results appear in E+1.
  task automatic run_fetch(input logic [31:0] pc, input int k, input int rr, input bit noise,
                           input bit clr0, input bit clr_e, input logic [31:0] data);
    int  e;
    bit  tmo, good;
    logic [4:0] got, exp;
    tmo  = (k == 0) || (k > TIMEOUT);
    e    = tmo ? 1 + TIMEOUT : 1 + k;
    good = !tmo && !(rr >= 2 && rr <= e);
    for (int t = 1; t <= e + 2; t++) begin
      int c;
      c = t - 1;
      pc_q     = (c == 0) ? pc : $urandom;
      start    = (c == 0) ? 1'b1 : (noise && c <= e && $urandom_range(0, 1) == 1);
      stall    = 1'b0;
      redirect = (c == rr);
      err_clr  = (c == 0 && clr0) || (c == e && clr_e);
      mem_bus.mem_ack  = (k != 0 && c == 1 + k) || (noise && c == 1);
      mem_bus.mem_data = (k != 0 && c == 1 + k) ? data : $urandom;
      tick;
      if (c == 0 && clr0) err_m = 1'b0;
      if (c == e) begin
        if (tmo) err_m = 1'b1;
        else if (clr_e) err_m = 1'b0;
        if (good) ir_m = data;
      end
      got = {mem_bus.mem_rd, busy, ir_valid, pc_inc, fetch_err};
      exp = {t <= e, t <= e, t == e + 1 && good, t == e + 1 && good, err_m};
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL ctrl{rd,busy,irv,inc,err} t=%0d k=%0d rr=%0d got=%b exp=%b", t, k, rr, got, exp);
      end
      vecs++;
      if (mem_bus.mem_addr !== pc) begin
        fails++;
        $display("FAIL mem_addr t=%0d got=%h exp=%h", t, mem_bus.mem_addr, pc);
      end
      vecs++;
      if (ir_q !== ir_m) begin
        fails++;
        $display("FAIL ir_q t=%0d got=%h exp=%h", t, ir_q, ir_m);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset;
    idle_inputs();
    clr_n = 1'b0;
    tick; tick;
    vecs++;
    if ({mem_bus.mem_addr, mem_bus.mem_rd, ir_q, ir_valid, pc_inc, busy, fetch_err} !== 69'd0) begin
      fails++;
      $display("FAIL reset_state got rd=%b busy=%b err=%b addr=%h ir=%h", mem_bus.mem_rd, busy,
               fetch_err, mem_bus.mem_addr, ir_q);
    end
    #2 clr_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int n0;
    n0 = n_inc;
    run_fetch(32'h0000_0040, 1, -1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    vecs++;
    if (n_inc - n0 !== 1) begin
      fails++;
      $display("FAIL basic_pc_inc_count got=%0d exp=1", n_inc - n0);
    end
  endtask

  task automatic test_redirect_late;
    run_fetch(32'h0000_0100, 5, 3, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
  endtask

  task automatic test_redirect_with_ack;
    run_fetch(32'h0000_0200, 2, 3, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D);
    run_fetch(32'h0000_0204, 3, 1, 1'b0, 1'b0, 1'b0, 32'h0BAD_C0DE);
  endtask

  task automatic test_timeout;
    run_fetch(32'h0000_0300, 0, -1, 1'b0, 1'b0, 1'b0, 32'h0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    err_m   = 1'b0;
    vecs++;
    if (fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clr got=%b exp=0", fetch_err);
    end
    run_fetch(32'h0000_0304, 0, 4, 1'b0, 1'b0, 1'b1, 32'h0);
    run_fetch(32'h0000_0308, 2, -1, 1'b0, 1'b0, 1'b0, 32'h5555_AAAA);
  endtask

  task automatic test_busy_start_stall;
    int n0;
    n0 = n_inc;
    start = 1'b1; stall = 1'b1; pc_q = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      tick;
      vecs++;
      if (busy !== 1'b0 || mem_bus.mem_rd !== 1'b0) begin
        fails++;
        $display("FAIL stall_start busy=%b rd=%b exp=0/0", busy, mem_bus.mem_rd);
      end
    end
    idle_inputs();
    run_fetch(32'h0000_0404, 4, -1, 1'b1, 1'b0, 1'b0, 32'h7777_1111);
    vecs++;
    if (n_inc - n0 !== 1) begin
      fails++;
      $display("FAIL single_fetch_count got=%0d exp=1", n_inc - n0);
    end
  endtask

  task automatic test_async_reset;
    pc_q = 32'h0000_0500; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    #2 clr_n = 1'b0;
    #1;
    ir_m = 32'd0; err_m = 1'b0;
    vecs++;
    if ({mem_bus.mem_addr, mem_bus.mem_rd, ir_q, ir_valid, pc_inc, busy, fetch_err} !== 69'd0) begin
      fails++;
      $display("FAIL async_reset got rd=%b busy=%b addr=%h ir=%h", mem_bus.mem_rd, busy,
               mem_bus.mem_addr, ir_q);
    end
    tick;
    #2 clr_n = 1'b1;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      tick;
      mem_bus.mem_ack = 1'b0;
      vecs++;
      if ({ir_valid, pc_inc, busy, mem_bus.mem_rd} !== 4'b0000 || ir_q !== 32'd0) begin
        fails++;
        $display("FAIL late_ack_after_reset irv=%b inc=%b busy=%b ir=%h", ir_valid, pc_inc, busy, ir_q);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      int k, rr;
      k  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) * (TIMEOUT + 1) : $urandom_range(1, 6);
      rr = ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, 8);
      run_fetch($urandom, k, rr, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_redirect_late();
    test_redirect_with_ack();
    test_timeout();
    test_busy_start_stall();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

`default_nettype wire
